// File: rtl/sel_accum_unit.sv
// Operand/select responder: captures a, accumulates it N times, publishes z.
// Define SEL_ACCUM_SATURATE_EN to clamp sums at 8'hFF instead of wrapping.
module sel_accum_unit #(
    parameter int N = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] a,
    input  logic       sel,
    output logic [7:0] z,
    output logic       done
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    localparam logic [1:0] LOAD = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [7:0]    areg;
    logic [7:0]    acc;
    logic [CW-1:0] cnt;
    logic [7:0]    sum;

`ifdef SEL_ACCUM_SATURATE_EN
    logic [8:0] sum9;
    assign sum9 = {1'b0, acc} + {1'b0, areg};
    // Once acc is 8'hFF any nonzero areg carries again, so it sticks.
    assign sum  = sum9[8] ? 8'hFF : sum9[7:0];
`else
    assign sum  = acc + areg;
`endif

    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
            areg  <= 8'h00;
            acc   <= 8'h00;
            cnt   <= '0;
            z     <= 8'h00;
        end else begin
            unique case (state)
                LOAD: begin
                    areg <= a;
                    acc  <= 8'h00;
                    cnt  <= '0;
                    if (sel) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!sel) begin
                        state <= LOAD;
                        acc   <= 8'h00;
                        cnt   <= '0;
                    end else begin
                        acc <= sum;
                        cnt <= cnt + ONE;
                        if (cnt == LAST) begin
                            z     <= sum;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!sel) begin
                        state <= LOAD;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sel_accum_unit.sv
// Directed and randomized bench for sel_accum_unit against an arithmetic model.
// Build with SEL_ACCUM_SATURATE_EN to check the clamping variant.
module tb_sel_accum_unit;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] a = 8'h00;
    logic       sel = 1'b0;
    logic [7:0] z;
    logic       done;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] zprev = 8'h00;

    sel_accum_unit #(.N(N)) dut (
        .clk  (clk),
        .reset(reset),
        .a    (a),
        .sel  (sel),
        .z    (z),
        .done (done)
    );

    always #5 clk = ~clk;

    // Result of adding v to itself n times, straight from the arithmetic rule.
    function automatic logic [7:0] model(input logic [7:0] v, input int n);
        int p;
        p = int'(v) * n;
`ifdef SEL_ACCUM_SATURATE_EN
        if (p > 255) p = 255;
`else
        p = p % 256;
`endif
        return p[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full run from LOAD or DONE: one load edge, one start edge, N run edges.
    task automatic run(input logic [7:0] av);
        logic [7:0] exp;
        exp = model(av, N);
        sel = 1'b0;
        a = av;
        tick();
        chk("load_done", {7'd0, done}, 8'h00);
        sel = 1'b1;
        tick();
        a = 8'($urandom);
        for (int i = 1; i <= N; i++) begin
            tick();
            if (i < N) begin
                chk("run_done", {7'd0, done}, 8'h00);
                chk("run_z", z, zprev);
            end else begin
                chk("fin_done", {7'd0, done}, 8'h01);
                chk("fin_z", z, exp);
            end
        end
        zprev = exp;
        tick();
        chk("hold_done", {7'd0, done}, 8'h01);
        chk("hold_z", z, exp);
    endtask

    // Start a run and drop sel at the j-th edge after the start edge.
    task automatic abort_run(input logic [7:0] av, input int j);
        sel = 1'b0;
        a = av;
        tick();
        sel = 1'b1;
        tick();
        for (int i = 1; i < j; i++) begin
            tick();
            chk("abort_mid_done", {7'd0, done}, 8'h00);
        end
        sel = 1'b0;
        tick();
        chk("abort_done", {7'd0, done}, 8'h00);
        chk("abort_z", z, zprev);
        tick();
        chk("abort_idle_done", {7'd0, done}, 8'h00);
        chk("abort_idle_z", z, zprev);
    endtask

    initial begin
        reset = 1'b1;
        sel = 1'b0;
        a = 8'h5A;
        tick();
        chk("rst1_z", z, 8'h00);
        chk("rst1_done", {7'd0, done}, 8'h00);
        tick();
        chk("rst2_z", z, 8'h00);
        chk("rst2_done", {7'd0, done}, 8'h00);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom);
            tick();
            chk("idle_z", z, 8'h00);
            chk("idle_done", {7'd0, done}, 8'h00);
        end

        run(8'h03);
        run(8'h50);

        abort_run(8'h07, 2);
        run(8'h0B);

        run(8'h02);
        run(8'h10);

        sel = 1'b0;
        a = 8'h21;
        tick();
        sel = 1'b1;
        tick();
        tick();
        tick();
        chk("prerst_z", z, zprev);
        reset = 1'b1;
        tick();
        chk("midrst_z", z, 8'h00);
        chk("midrst_done", {7'd0, done}, 8'h00);
        tick();
        chk("rstsel_z", z, 8'h00);
        chk("rstsel_done", {7'd0, done}, 8'h00);
        zprev = 8'h00;
        reset = 1'b0;
        sel = 1'b0;
        tick();
        chk("postrst_done", {7'd0, done}, 8'h00);
        run(8'h09);

        for (int r = 0; r < 24; r++) begin
            logic [7:0] av;
            av = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                abort_run(av, int'($urandom_range(1, N)));
            end else begin
                run(av);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
